// File: rtl/sse_accum_fx.sv
// sse_accum_fx: pipelined fixed-point sum-of-squared-error / sum-of-absolute-error accumulator.
//
// Each accepted beat carries LANES signed (A, B) pairs. The per-lane error is reduced to one
// lane sum and added into a saturating ACC_W accumulator. A frame is closed by `last`. The
// result is then presented on Y/count/sat under an out_valid/out_ready handshake.
//
// Pipeline for a beat accepted at edge E:
//   E   : diff = A - B per lane (DATA_W+1 bits, signed)
//   E+1 : magnitude per lane (diff^2 or |diff|, 2*DATA_W bits, unsigned)
//   E+2 : adder-tree lane sum (2*DATA_W + log2(LANES) bits)
//   E+3 : acc += lane sum (saturating)
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input beat handshake; in_ready is high only while accumulating
//   A, B                 LANES packed signed operands, lane i at [i*DATA_W +: DATA_W]
//   last                 accepted beat closes the frame
//   mode                 0 = squared error, 1 = absolute error (taken from the first beat)
//   out_valid/out_ready  result handshake
//   Y, count, sat        frame sum, accepted beat count (saturating), sticky saturation flag
module sse_accum_fx #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LANES  = 2,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] A,
  input  logic [LANES*DATA_W-1:0] B,
  input  logic                    last,
  input  logic                    mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_W-1:0]        Y,
  output logic [CNT_W-1:0]        count,
  output logic                    sat
);

  localparam int unsigned LogL   = $clog2(LANES);
  localparam int unsigned DiffW  = DATA_W + 1;
  localparam int unsigned MagW   = 2 * DATA_W;
  localparam int unsigned SumW   = 2 * DATA_W + LogL;
  localparam int unsigned NNodes = 2 * LANES - 1;

  // Elaboration-time parameter checks.
  if (ACC_W < SumW) begin : g_acc_w_chk
    $error("sse_accum_fx: ACC_W must be >= 2*DATA_W + log2(LANES)");
  end
  if ((LANES < 1) || (LANES > 8) || ((LANES & (LANES - 1)) != 0)) begin : g_lanes_chk
    $error("sse_accum_fx: LANES must be a power of two in 1..8");
  end

  // ---------------------------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------------------------
  typedef enum logic [1:0] {
    StAccum,
    StDrain,
    StHold
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] drain_cnt_q, drain_cnt_d;
  logic       accept;
  logic       load_y;
  logic       frame_done;

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    in_ready    = 1'b0;
    load_y      = 1'b0;
    frame_done  = 1'b0;
    unique case (state_q)
      StAccum: begin
        in_ready = 1'b1;
        if (in_valid && last) begin
          state_d     = StDrain;
          drain_cnt_d = 2'd0;
        end
      end
      StDrain: begin
        // The last beat sits in the sum stage when the counter reads 2, so it lands in the
        // accumulator on this edge and Y can load the updated value.
        drain_cnt_d = drain_cnt_q + 2'd1;
        if (drain_cnt_q == 2'd2) begin
          state_d = StHold;
          load_y  = 1'b1;
        end
      end
      StHold: begin
        if (out_ready) begin
          state_d    = StAccum;
          frame_done = 1'b1;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------------------------
  // Frame bookkeeping: mode latch, beat counter
  // ---------------------------------------------------------------------------------------------
  logic             started_q, started_d;
  logic             mode_q, mode_d;
  logic             beat_mode;
  logic [CNT_W-1:0] count_q, count_d;

  // The first beat of a frame uses the live mode pin; later beats use the latched copy.
  assign beat_mode = started_q ? mode_q : mode;

  always_comb begin
    started_d = started_q;
    mode_d    = mode_q;
    count_d   = count_q;
    if (frame_done) begin
      started_d = 1'b0;
      mode_d    = 1'b0;
      count_d   = '0;
    end else if (accept) begin
      if (!started_q) begin
        started_d = 1'b1;
        mode_d    = mode;
      end
      if (count_q != {CNT_W{1'b1}}) begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 1: per-lane difference
  // ---------------------------------------------------------------------------------------------
  logic [DiffW-1:0] diff_d [LANES];
  logic [DiffW-1:0] diff_q [LANES];
  logic             v1_q;
  logic             m1_q;

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      diff_d[l] = {A[l*DATA_W + DATA_W - 1], A[l*DATA_W +: DATA_W]}
                - {B[l*DATA_W + DATA_W - 1], B[l*DATA_W +: DATA_W]};
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2: per-lane magnitude
  // ---------------------------------------------------------------------------------------------
  logic [MagW-1:0] mag_d [LANES];
  logic [MagW-1:0] mag_q [LANES];
  logic            v2_q;

  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      logic [DATA_W-1:0] abs_v;
      // |diff| <= 2^DATA_W - 1, so negation fits in the low DATA_W bits.
      abs_v = diff_q[l][DATA_W] ? (~diff_q[l][DATA_W-1:0] + DATA_W'(1))
                                : diff_q[l][DATA_W-1:0];
      if (m1_q) begin
        mag_d[l] = MagW'(abs_v);
      end else begin
        mag_d[l] = MagW'(abs_v) * MagW'(abs_v);
      end
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 3: adder tree
  // ---------------------------------------------------------------------------------------------
  logic [SumW-1:0] sum_d;
  logic [SumW-1:0] sum_q;
  logic            v3_q;

  always_comb begin : p_tree
    // Heap layout: node n has children 2n+1 and 2n+2, leaves at LANES-1 .. 2*LANES-2.
    logic [SumW-1:0] tree [NNodes];
    for (int unsigned l = 0; l < LANES; l++) begin
      tree[LANES - 1 + l] = SumW'(mag_q[l]);
    end
    for (int n = int'(LANES) - 2; n >= 0; n--) begin
      tree[n] = tree[2*n + 1] + tree[2*n + 2];
    end
    sum_d = tree[0];
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 4: saturating accumulator and result register
  // ---------------------------------------------------------------------------------------------
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             sat_q, sat_d;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] y_q, y_d;
  logic             out_valid_q, out_valid_d;

  assign acc_sum = {1'b0, acc_q} + (ACC_W+1)'(sum_q);

  always_comb begin
    acc_d = acc_q;
    sat_d = sat_q;
    if (frame_done) begin
      acc_d = '0;
      sat_d = 1'b0;
    end else if (v3_q) begin
      // Once saturated, acc stays pinned at all-ones for the rest of the frame.
      if (sat_q || acc_sum[ACC_W]) begin
        acc_d = {ACC_W{1'b1}};
        sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_W-1:0];
      end
    end
  end

  always_comb begin
    y_d         = y_q;
    out_valid_d = out_valid_q;
    if (load_y) begin
      y_d         = acc_d;
      out_valid_d = 1'b1;
    end else if (frame_done) begin
      out_valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAccum;
      drain_cnt_q <= 2'd0;
      started_q   <= 1'b0;
      mode_q      <= 1'b0;
      count_q     <= '0;
      v1_q        <= 1'b0;
      m1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      sum_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
        diff_q[l] <= '0;
        mag_q[l]  <= '0;
      end
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      started_q   <= started_d;
      mode_q      <= mode_d;
      count_q     <= count_d;
      v1_q        <= accept;
      m1_q        <= beat_mode;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      for (int unsigned l = 0; l < LANES; l++) begin
        // Only accepted beats enter the pipe; bubbles leave stale data marked invalid.
        if (accept) begin
          diff_q[l] <= diff_d[l];
        end
        if (v1_q) begin
          mag_q[l] <= mag_d[l];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign Y         = y_q;
  assign count     = count_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_sse_accum_fx.sv
module tb_sse_accum_fx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, last, mode, out_ready;
  logic [31:0] A, B;

  logic        in_ready, out_valid, sat;
  logic [47:0] Y;
  logic [15:0] count;

  logic        in_ready_s, out_valid_s, sat_s;
  logic [32:0] Y_s;
  logic [2:0]  count_s;

  always #5 clk = ~clk;

  sse_accum_fx #(.DATA_W(16), .LANES(2), .ACC_W(48), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .last(last), .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .Y(Y),
    .count(count), .sat(sat)
  );

  // Narrow instance: minimum legal accumulator and a 3-bit counter to reach saturation quickly.
  sse_accum_fx #(.DATA_W(16), .LANES(2), .ACC_W(33), .CNT_W(3)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .A(A), .B(B),
    .last(last), .mode(mode), .out_valid(out_valid_s), .out_ready(out_ready), .Y(Y_s),
    .count(count_s), .sat(sat_s)
  );

  int errors = 0;
  int checks = 0;

  int qa0[$], qa1[$], qb0[$], qb1[$];
  bit frame_mode;
  bit toggle_mode;
  int min_gap, max_gap;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    qa0.delete(); qa1.delete(); qb0.delete(); qb1.delete();
  endtask

  task automatic push(input int a0, input int b0, input int a1, input int b1);
    qa0.push_back(a0); qb0.push_back(b0); qa1.push_back(a1); qb1.push_back(b1);
  endtask

  // Frame result straight from the rules: per beat, sum the lane errors, then add with clamp.
  function automatic void model(input int acc_w, input int cnt_w,
                                output logic [63:0] y, output logic [63:0] c, output logic s);
    longint unsigned acc = 0;
    longint unsigned lim = 64'd1 << acc_w;
    longint unsigned lim_c = (64'd1 << cnt_w) - 1;
    s = 1'b0;
    for (int i = 0; i < qa0.size(); i++) begin
      longint d0 = longint'(qa0[i]) - longint'(qb0[i]);
      longint d1 = longint'(qa1[i]) - longint'(qb1[i]);
      longint unsigned e0 = frame_mode ? longint'(d0 < 0 ? -d0 : d0) : longint'(d0 * d0);
      longint unsigned e1 = frame_mode ? longint'(d1 < 0 ? -d1 : d1) : longint'(d1 * d1);
      acc = acc + e0 + e1;
      if (acc >= lim) begin
        acc = lim - 1;
        s   = 1'b1;
      end
    end
    y = acc;
    c = (longint'(qa0.size()) > longint'(lim_c)) ? lim_c : 64'(qa0.size());
  endfunction

  task automatic junk_inputs();
    A    = $urandom;
    B    = $urandom;
    last = 1'($urandom);
    mode = 1'($urandom);
  endtask

  // Called at a negedge; returns at the negedge right after the last beat was accepted.
  task automatic send_frame(input string tag);
    for (int i = 0; i < qa0.size(); i++) begin
      A        = {16'(qa1[i]), 16'(qa0[i])};
      B        = {16'(qb1[i]), 16'(qb0[i])};
      in_valid = 1'b1;
      last     = (i == qa0.size() - 1);
      if (i == 0)           mode = frame_mode;
      else if (toggle_mode) mode = ~frame_mode;
      else                  mode = 1'($urandom);
      out_ready = 1'($urandom);
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      junk_inputs();
      if (i != qa0.size() - 1 && max_gap > 0) begin
        repeat ($urandom_range(max_gap, min_gap)) @(negedge clk);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic expect_result(input string tag,
                               input logic [63:0] y48, input logic [63:0] c16, input logic s48,
                               input logic [63:0] y33, input logic [63:0] c3, input logic s33);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'd3);
    chk({tag, "_y"}, 64'(Y), y48);
    chk({tag, "_count"}, 64'(count), c16);
    chk({tag, "_sat"}, 64'(sat), 64'(s48));
    chk({tag, "_in_ready_hold"}, 64'(in_ready), 64'd0);
    chk({tag, "_s_valid"}, 64'(out_valid_s), 64'd1);
    chk({tag, "_s_y"}, 64'(Y_s), y33);
    chk({tag, "_s_count"}, 64'(count_s), c3);
    chk({tag, "_s_sat"}, 64'(sat_s), 64'(s33));
  endtask

  task automatic expect_model(input string tag);
    logic [63:0] y48, c16, y33, c3;
    logic s48, s33;
    model(48, 16, y48, c16, s48);
    model(33, 3, y33, c3, s33);
    expect_result(tag, y48, c16, s48, y33, c3, s33);
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rel_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_rel_count"}, 64'(count), 64'd0);
    chk({tag, "_rel_sat"}, 64'(sat), 64'd0);
  endtask

  initial begin
    logic [63:0] held_y;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    junk_inputs();
    min_gap     = 0;
    max_gap     = 0;
    toggle_mode = 1'b0;
    frame_mode  = 1'b0;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_y", 64'(Y), 64'd0);
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_sat", 64'(sat), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    // Squared error on lane 0, lane 1 zero-difference: 9 + 49 + 0.
    clear_frame();
    push(5, 2, 1234, 1234);
    push(-3, 4, -77, -77);
    push(100, 100, 0, 0);
    frame_mode = 1'b0;
    send_frame("sq3");
    expect_result("sq3", 64'd58, 64'd3, 1'b0, 64'd58, 64'd3, 1'b0);
    release_result("sq3");

    // Same beats, absolute error with mode flipped on every later beat: 3 + 7 + 0.
    frame_mode  = 1'b1;
    toggle_mode = 1'b1;
    send_frame("abs3");
    expect_result("abs3", 64'd10, 64'd3, 1'b0, 64'd10, 64'd3, 1'b0);
    toggle_mode = 1'b0;

    // Hold the result for 10 cycles while offering beats: nothing may be absorbed.
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      junk_inputs();
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_y", 64'(Y), 64'd10);
      chk("hold_count", 64'(count), 64'd3);
    end
    in_valid = 1'b0;
    release_result("abs3");

    // Single extreme beat: both lane errors are 65535^2.
    clear_frame();
    push(-32768, 32767, 32767, -32768);
    frame_mode = 1'b0;
    send_frame("ext1");
    expect_result("ext1", 64'd8589672450, 64'd1, 1'b0, 64'd8589672450, 64'd1, 1'b0);
    release_result("ext1");

    // Two extreme beats overflow the 33-bit accumulator but not the 48-bit one.
    push(-32768, 32767, 32767, -32768);
    send_frame("ext2");
    expect_result("ext2", 64'd17179344900, 64'd2, 1'b0, 64'h1_FFFF_FFFF, 64'd2, 1'b1);
    release_result("ext2");

    // Reset after two beats of a frame discards everything.
    in_valid = 1'b1;
    last     = 1'b0;
    mode     = 1'b0;
    A        = {16'd9, 16'd50};
    B        = {16'd0, 16'd0};
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b1;
    last = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_y", 64'(Y), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_sat", 64'(sat), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    repeat (4) @(negedge clk);
    clear_frame();
    push(7, -1, 0, 0);
    frame_mode = 1'b0;
    send_frame("postrst");
    expect_result("postrst", 64'd64, 64'd1, 1'b0, 64'd64, 64'd1, 1'b0);
    release_result("postrst");

    // Four (1,0) beats with 1..3 idle cycles between them.
    clear_frame();
    repeat (4) push(1, 0, 1, 0);
    min_gap = 1;
    max_gap = 3;
    send_frame("gaps");
    expect_result("gaps", 64'd8, 64'd4, 1'b0, 64'd8, 64'd4, 1'b0);
    release_result("gaps");

    // Nine beats: the 3-bit counter pins at 7.
    clear_frame();
    repeat (9) push(1, 0, 0, 1);
    min_gap = 0;
    max_gap = 0;
    send_frame("cnt9");
    expect_result("cnt9", 64'd18, 64'd9, 1'b0, 64'd18, 64'd7, 1'b0);
    held_y = 64'(Y);
    release_result("cnt9");

    // Randomized frames against the reference model.
    for (int f = 0; f < 25; f++) begin
      int len = $urandom_range(12, 1);
      bit big = 1'($urandom);
      clear_frame();
      for (int i = 0; i < len; i++) begin
        if (big) push($urandom_range(65535, 0) - 32768, $urandom_range(65535, 0) - 32768,
                      $urandom_range(65535, 0) - 32768, $urandom_range(65535, 0) - 32768);
        else     push($urandom_range(20, 0) - 10, $urandom_range(20, 0) - 10,
                      $urandom_range(20, 0) - 10, $urandom_range(20, 0) - 10);
      end
      frame_mode  = 1'($urandom);
      toggle_mode = 1'($urandom);
      min_gap     = 0;
      max_gap     = $urandom_range(3, 0);
      send_frame("rnd");
      expect_model("rnd");
      repeat ($urandom_range(3, 0)) @(negedge clk);
      release_result("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
